// File: rtl/edge_delay_meter_pkg.sv
// Shared types and defaults for the edge delay meter.
// Optional feature macro: INPUT_SYNC_EN (input synchronizers).
package edge_delay_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNT,
        REPORT
    } state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/edge_delay_meter_edge_detect.sv
// Toggle detector: optional 2-flop synchronizer plus history register.
// Define INPUT_SYNC_EN to insert the synchronizer ahead of the history reg.
module edge_detect
    import edge_delay_meter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_s;
    logic hist_q;
    logic hist_d;

`ifdef INPUT_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    // Synchronizer next-state: shift the raw input through two stages
    always_comb begin
        sync1_d = sig_i;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = sig_i;
`endif

    // History tracks the (possibly synchronized) input every cycle
    always_comb begin
        hist_d = sig_s;
    end

    // History register, cleared on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign edge_o = sig_s ^ hist_q;

endmodule

// File: rtl/edge_delay_meter.sv
// Measures cycles between a toggle on a and the next toggle on y.
// Build option: INPUT_SYNC_EN adds input synchronizers in edge_detect.
module edge_delay_meter
    import edge_delay_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a,
    input  logic             y,
    input  logic             arm,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_timeout
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic a_edge;
    logic y_edge;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_d;
    logic             to_q;
    logic             to_d;

    edge_detect u_a_edge (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (a),
        .edge_o (a_edge)
    );

    edge_detect u_y_edge (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (y),
        .edge_o (y_edge)
    );

    // Next-state, counter and result capture; edges matter only in ARMED/COUNT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (a_edge && y_edge) begin
                    state_d = REPORT;
                    cyc_d   = '0;
                    to_d    = 1'b0;
                end else if (a_edge) begin
                    state_d = COUNT;
                    cnt_d   = ONE;
                end
            end
            COUNT: begin
                if (y_edge) begin
                    state_d = REPORT;
                    cyc_d   = cnt_q;
                    to_d    = 1'b0;
                end else if (cnt_q == TO_VAL) begin
                    state_d = REPORT;
                    cyc_d   = TO_VAL;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            REPORT: begin
                if (meas_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign meas_valid   = (state_q == REPORT);
    assign meas_cycles  = cyc_q;
    assign meas_timeout = to_q;

endmodule
